// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl: time-shares one window comparator over NCH channels,
// filters results per channel and raises sticky high/low alarms.
module window_scan_ctrl #(
  parameter int NCH = 4,
  parameter int W = 4,
  parameter int PERSIST = 3,
  localparam int CW = $clog2(NCH)
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  output logic           Busy,
  output logic           Done,
  input  logic           Cfg_Write,
  input  logic [CW-1:0]  Cfg_Chan,
  input  logic [W-1:0]   Cfg_Top,
  input  logic [W-1:0]   Cfg_Bottom,
  input  logic [NCH*W-1:0] Chan_Value,
  output logic [W-1:0]   Cmp_Top,
  output logic [W-1:0]   Cmp_Value,
  output logic [W-1:0]   Cmp_Bottom,
  input  logic           Too_High,
  input  logic           OK,
  input  logic           Too_Low,
  output logic [NCH-1:0] Alarm_High,
  output logic [NCH-1:0] Alarm_Low,
  input  logic [NCH-1:0] Clear
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(NCH - 1);
  localparam logic [2:0] P_SAT = 3'(PERSIST);

  state_t state, nxt_state;
  logic [CW-1:0] chan, nxt_chan;

  logic [W-1:0] top_tbl [NCH];
  logic [W-1:0] bot_tbl [NCH];
  logic [2:0] hi_cnt [NCH];
  logic [2:0] lo_cnt [NCH];

  logic [2:0] cur_hi, cur_lo;
  logic [2:0] nxt_hi, nxt_lo;
  logic is_hi, is_lo, is_ok;
  logic cfg_ok;

  assign cfg_ok = int'(Cfg_Chan) < NCH;

  // Scan state and channel pointer
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
      chan <= '0;
    end else begin
      state <= nxt_state;
      chan <= nxt_chan;
    end
  end

  // Next-state sequencing and status outputs
  always_comb begin
    nxt_state = state;
    nxt_chan = chan;
    Busy = 1'b0;
    Done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Start) begin
          nxt_state = S_DRIVE;
          nxt_chan = '0;
        end
      end
      S_DRIVE: begin
        Busy = 1'b1;
        nxt_state = S_SAMPLE;
      end
      S_SAMPLE: begin
        Busy = 1'b1;
        if (chan == LAST) begin
          nxt_state = S_DONE;
        end else begin
          nxt_chan = chan + 1'b1;
          nxt_state = S_DRIVE;
        end
      end
      S_DONE: begin
        Done = 1'b1;
        nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Limit table, writable in any state
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NCH; i++) begin
        top_tbl[i] <= '1;
        bot_tbl[i] <= '0;
      end
    end else if (Cfg_Write && cfg_ok) begin
      top_tbl[Cfg_Chan] <= Cfg_Top;
      bot_tbl[Cfg_Chan] <= Cfg_Bottom;
    end
  end

  // Comparator drive, latched once per channel in DRIVE
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Cmp_Top <= '1;
      Cmp_Value <= '0;
      Cmp_Bottom <= '0;
    end else if (state == S_DRIVE) begin
      Cmp_Top <= top_tbl[chan];
      Cmp_Bottom <= bot_tbl[chan];
      Cmp_Value <= Chan_Value[int'(chan)*W +: W];
    end
  end

  assign is_hi = Too_High;
  assign is_lo = !Too_High && Too_Low;
  assign is_ok = !Too_High && !Too_Low && OK;

  // Filter update for the channel under sample
  always_comb begin
    cur_hi = hi_cnt[chan];
    cur_lo = lo_cnt[chan];
    nxt_hi = '0;
    nxt_lo = '0;
    unique case (1'b1)
      is_hi: nxt_hi = (cur_hi == P_SAT) ? P_SAT : cur_hi + 3'd1;
      is_lo: nxt_lo = (cur_lo == P_SAT) ? P_SAT : cur_lo + 3'd1;
      is_ok: begin
        nxt_hi = '0;
        nxt_lo = '0;
      end
      default: begin
        nxt_hi = '0;
        nxt_lo = '0;
      end
    endcase
  end

  // Counters and sticky alarms; a set beats a same-edge clear
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Alarm_High <= '0;
      Alarm_Low <= '0;
      for (int i = 0; i < NCH; i++) begin
        hi_cnt[i] <= '0;
        lo_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (Clear[i]) begin
          Alarm_High[i] <= 1'b0;
          Alarm_Low[i] <= 1'b0;
        end
        if (state == S_SAMPLE && chan == CW'(i)) begin
          hi_cnt[i] <= nxt_hi;
          lo_cnt[i] <= nxt_lo;
          if (nxt_hi == P_SAT) Alarm_High[i] <= 1'b1;
          if (nxt_lo == P_SAT) Alarm_Low[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// tb_window_scan_ctrl: directed checks of scan timing, filtering,
// alarms, handshake and mid-scan reset for window_scan_ctrl.
module tb_window_scan_ctrl;

  localparam int NCH = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic Reset, Start, Busy, Done;
  logic Cfg_Write;
  logic [1:0] Cfg_Chan;
  logic [W-1:0] Cfg_Top, Cfg_Bottom;
  logic [NCH*W-1:0] Chan_Value;
  logic [W-1:0] Cmp_Top, Cmp_Value, Cmp_Bottom;
  logic Too_High, OK, Too_Low;
  logic [NCH-1:0] Alarm_High, Alarm_Low, Clear;

  int checks = 0;
  int errors = 0;

  logic [3:0] ah [10];
  logic [3:0] al [10];
  logic [3:0] cv [10];
  logic [3:0] ct [10];
  logic dn [10];
  logic bz [10];
  logic bz0;
  int done_cnt;
  logic done_any;

  window_scan_ctrl #(.NCH(NCH), .W(W), .PERSIST(3)) dut (
    .Clock(clk),
    .Reset(Reset),
    .Start(Start),
    .Busy(Busy),
    .Done(Done),
    .Cfg_Write(Cfg_Write),
    .Cfg_Chan(Cfg_Chan),
    .Cfg_Top(Cfg_Top),
    .Cfg_Bottom(Cfg_Bottom),
    .Chan_Value(Chan_Value),
    .Cmp_Top(Cmp_Top),
    .Cmp_Value(Cmp_Value),
    .Cmp_Bottom(Cmp_Bottom),
    .Too_High(Too_High),
    .OK(OK),
    .Too_Low(Too_Low),
    .Alarm_High(Alarm_High),
    .Alarm_Low(Alarm_Low),
    .Clear(Clear)
  );

  // External window comparator
  assign Too_High = Cmp_Value > Cmp_Top;
  assign Too_Low = Cmp_Value < Cmp_Bottom;
  assign OK = !Too_High && !Too_Low;

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One scan from capture edge E0; index k holds outputs after E0+k
  task automatic scan(input int clr_k, input logic [3:0] clr_v,
                      input int st_k, input int cfg_k);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    bz0 = Busy;
    for (int k = 1; k <= 9; k++) begin
      if (k == clr_k) Clear = clr_v;
      if (k == st_k) Start = 1'b1;
      if (k == cfg_k) begin
        Cfg_Write = 1'b1;
        Cfg_Chan = 2'd2;
        Cfg_Top = 4'd6;
        Cfg_Bottom = 4'd4;
      end
      tick();
      Clear = '0;
      Start = 1'b0;
      Cfg_Write = 1'b0;
      ah[k] = Alarm_High;
      al[k] = Alarm_Low;
      dn[k] = Done;
      bz[k] = Busy;
      cv[k] = Cmp_Value;
      ct[k] = Cmp_Top;
    end
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Cfg_Write = 1'b0;
    Cfg_Chan = '0;
    Cfg_Top = '0;
    Cfg_Bottom = '0;
    Chan_Value = 16'hFFFF;
    Clear = '0;
    tick();
    tick();
    Reset = 1'b0;

    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_ah", Alarm_High, 0);
    check("rst_al", Alarm_Low, 0);
    check("rst_top", Cmp_Top, 15);
    check("rst_bot", Cmp_Bottom, 0);
    check("rst_val", Cmp_Value, 0);

    // All values 15 against default limits
    scan(0, 0, 0, 0);
    check("s0_busy0", bz0, 1);
    check("s0_busy7", bz[7], 1);
    check("s0_done7", dn[7], 0);
    check("s0_done8", dn[8], 1);
    check("s0_busy8", bz[8], 0);
    check("s0_done9", dn[9], 0);
    check("s0_ah", ah[9], 0);
    check("s0_al", al[9], 0);

    // Limits 11/4 on every channel
    for (int c = 0; c < NCH; c++) begin
      Cfg_Write = 1'b1;
      Cfg_Chan = 2'(c);
      Cfg_Top = 4'd11;
      Cfg_Bottom = 4'd4;
      tick();
    end
    Cfg_Write = 1'b0;

    Chan_Value = 16'hB73C;
    scan(0, 0, 0, 0);
    check("p1_val0", cv[1], 12);
    check("p1_top0", ct[1], 11);
    check("p1_val1", cv[3], 3);
    check("p1_val3", cv[7], 11);
    check("p1_ah", ah[9], 0);
    check("p1_al", al[9], 0);
    scan(0, 0, 0, 0);
    check("p2_ah", ah[9], 0);
    check("p2_al", al[9], 0);
    scan(0, 0, 0, 0);
    check("p3_ah_pre", ah[1], 0);
    check("p3_ah_set", ah[2], 4'b0001);
    check("p3_al_pre", al[3], 0);
    check("p3_al_set", al[4], 4'b0010);
    check("p3_ah_end", ah[9], 4'b0001);
    check("p3_al_end", al[9], 4'b0010);

    // Clear all, then persistence broken by an in-window scan
    Clear = 4'hF;
    tick();
    Clear = '0;
    check("clr_ah", Alarm_High, 0);
    check("clr_al", Alarm_Low, 0);
    Chan_Value = 16'h7777;
    scan(0, 0, 0, 0);
    check("pb0_ah", ah[9], 0);
    Chan_Value = 16'h777C;
    scan(0, 0, 0, 0);
    scan(0, 0, 0, 0);
    check("pb2_ah", ah[9], 0);
    Chan_Value = 16'h7777;
    scan(0, 0, 0, 0);
    check("pb3_ah", ah[9], 0);
    Chan_Value = 16'h777C;
    scan(0, 0, 0, 0);
    scan(0, 0, 0, 0);
    check("pb5_ah", ah[9], 0);
    scan(0, 0, 0, 0);
    check("pb6_ah", ah[9], 4'b0001);
    check("pb6_al", al[9], 0);

    // Clear on ch0 SAMPLE edge while saturated: set wins
    scan(2, 4'b0001, 0, 0);
    check("col_ah", ah[2], 4'b0001);
    check("col_end", ah[9], 4'b0001);
    Clear = 4'b0001;
    tick();
    Clear = '0;
    check("clr0_ah", Alarm_High, 0);
    scan(0, 0, 0, 0);
    check("reraise_pre", ah[1], 0);
    check("reraise", ah[2], 4'b0001);
    Clear = 4'b0001;
    tick();
    Clear = '0;
    Chan_Value = 16'h7777;
    scan(0, 0, 0, 0);
    check("clr7_ah", ah[9], 0);
    tick();
    check("clr7_hold", Alarm_High, 0);

    // Start held high: back-to-back scans every 10 cycles
    Chan_Value = 16'h777C;
    done_cnt = 0;
    Start = 1'b1;
    tick();
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 29) Start = 1'b0;
      if (Done) done_cnt++;
      if (k == 8 || k == 18 || k == 28) begin
        check($sformatf("bb_done%0d", k), Done, 1);
      end
    end
    check("bb_count", done_cnt, 3);
    check("bb_idle", Busy, 0);
    check("bb_ah", Alarm_High, 4'b0001);

    // Start pulsed mid-scan is dropped
    scan(0, 0, 4, 0);
    check("ign_done8", dn[8], 1);
    tick();
    check("ign_idle", Busy, 0);

    // Config write for ch2 lands before its DRIVE
    scan(0, 0, 0, 3);
    check("cfg_top0", ct[1], 11);
    check("cfg_top2", ct[5], 6);
    check("cfg_val2", cv[5], 7);
    check("cfg_ah", ah[9], 4'b0001);

    // Reset during SAMPLE of ch1 aborts the scan
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("ar_busy", Busy, 0);
    check("ar_done", Done, 0);
    check("ar_ah", Alarm_High, 0);
    check("ar_al", Alarm_Low, 0);
    check("ar_top", Cmp_Top, 15);
    done_any = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      done_any = done_any | Done;
    end
    check("ar_nodone", done_any, 0);
    scan(0, 0, 0, 0);
    check("ar_busy0", bz0, 1);
    check("ar_done7", dn[7], 0);
    check("ar_done8", dn[8], 1);
    check("ar_tbl", ct[1], 15);
    check("ar_ah2", ah[9], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_scan_ctrl.md
# window_scan_ctrl

Scan controller that time-shares one `window` comparator across NCH monitored channels. On each Start it presents every channel's value and limits to the shared comparator in turn and collects Too_High/OK/Too_Low. It applies a per-channel persistence filter and raises sticky high/low alarms. It sits between the channel sample registers and a single external `window` instance.

## Interface
- NCH, 4: number of channels (2..8); channel index width CW = clog2(NCH)
- W, 4: value/limit width
- PERSIST, 3: consecutive out-of-window scans required to raise an alarm (1..7)

- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high; one clock; all state below returns to reset values
- Start  in  1  request one full scan; sampled in IDLE only
- Busy  out  1  high in DRIVE/SAMPLE states; reset 0
- Done  out  1  one-cycle pulse after the last channel is sampled; reset 0
- Cfg_Write  in  1  load limits for Cfg_Chan
- Cfg_Chan  in  CW  channel index for config write (values >= NCH ignored)
- Cfg_Top, Cfg_Bottom  in  W each  new top/bottom limit
- Chan_Value  in  NCH*W  packed live channel values, channel i at [i*W +: W]
- Cmp_Top, Cmp_Value, Cmp_Bottom  out  W each  registered drive to comparator; reset Top = all ones, Value = 0, Bottom = 0
- Too_High, OK, Too_Low  in  1 each  comparator results (combinational from Cmp_*)
- Alarm_High, Alarm_Low  out  NCH each  sticky per-channel alarms; reset 0
- Clear  in  NCH  per-channel alarm clear

## Operation
- Limit table: NCH × {Top, Bottom} registers; reset Top = 2^W-1, Bottom = 0, so a fresh channel never alarms. Cfg_Write is accepted in any state. It takes effect from the next DRIVE of that channel. A write during that channel's SAMPLE does not alter the result in flight.
- FSM states IDLE, DRIVE, SAMPLE, DONE; reset state IDLE, chan = 0.
  - IDLE: Start=1 -> DRIVE, chan = 0. Start in any other state is ignored; requests are not queued.
  - DRIVE: latch Cmp_Top/Cmp_Bottom from table[chan] and Cmp_Value from Chan_Value[chan] -> SAMPLE.
  - SAMPLE: update filter for chan. If chan = NCH-1 -> DONE, else chan+1 -> DRIVE.
  - DONE: Done=1 -> IDLE.
- Result decode in SAMPLE uses the priority Too_High > Too_Low > OK. If no result input is asserted, the sample is treated as OK.
- Per-channel filter, with two saturating counters hi_cnt and lo_cnt, width 3, reset 0:
  - high result: hi_cnt = min(hi_cnt+1, PERSIST), lo_cnt = 0
  - low result: lo_cnt = min(lo_cnt+1, PERSIST), hi_cnt = 0
  - OK result: both counters = 0
  - Alarm_High[i] sets on the SAMPLE edge where the updated hi_cnt equals PERSIST; same rule for Alarm_Low[i] with lo_cnt.
- Clear[i] clears both alarms of channel i on any edge, and leaves the counters untouched. If a set and Clear[i] hit the same edge, set wins. A saturated counter re-raises its alarm on the next out-of-window sample.
- Alarm_High[i] and Alarm_Low[i] may both be 1 only if one went stale uncleared; a new set of one does not clear the other.
- Chan_Value is sampled only in DRIVE; changes at other times have no effect.

## Timing
- Start captured at edge E0 -> Busy=1 from E0. Channel k is DRIVEn at edge E0+2k+1 and SAMPLEd at edge E0+2k+2.
- Done is high for the single cycle after edge E0+2·NCH; Busy is 0 during that cycle. Earliest next Start capture is the edge ending the Done cycle +1 (IDLE).
- Scan period is 2·NCH+2 cycles; for NCH=4, Done occurs 9 cycles after capture.
- An alarm becomes visible in the cycle after its channel's SAMPLE edge.
- Reset mid-scan aborts the scan: next cycle Busy=0, Done=0, IDLE. Limits, counters and alarms return to reset values. No Done pulse is produced for the aborted scan.

## Test plan
- Reset values: after Reset, check Busy=0, Done=0, Alarm_*=0 and Cmp_Top=15, Cmp_Bottom=0. A scan with all channel values = 15 completes with Done exactly 9 cycles after capture and no alarms.
- Limits 11/4 on all channels; values ch0=12, ch1=3, ch2=7, ch3=11; 3 scans. Required: Alarm_High=0001 and Alarm_Low=0010 appear after scan 3's SAMPLE of ch0 and ch1 respectively, never before.
- Persistence break: ch0=12 for 2 scans, then 7, then 12 for 2 scans -> no alarm. A 3rd consecutive scan at 12 raises Alarm_High[0].
- Clear/set collision: ch0 saturated at 12, Clear[0] asserted on ch0's SAMPLE edge -> Alarm_High[0] stays 1. Clear[0] alone with ch0=7 -> alarm drops to 0 and stays 0.
- Handshake: Start held high continuously -> back-to-back scans every 10 cycles with one Done each. Start pulsed during Busy -> ignored. Cfg_Write to ch2 (Top=6) mid-scan before ch2's DRIVE -> applied in that scan.
- Reset asserted during SAMPLE of ch1 -> next cycle IDLE, Busy=0, no Done, alarms 0. A fresh Start then runs a full 9-cycle scan.
